pp_compressor_mul13: RTL and testbench
======================================

// Module: pp_compressor_mul13
// PURPOSE
//   Pipelined partial-product compressor for a 13x13 unsigned multiplier.
//   Takes 25 weighted bit columns (heights 1,2,..,13,..,2,1) and outputs their
//   weighted sum as 26 single-bit result columns. Sits between the AND-array
//   partial-product generator and the product register.
// PARAMETERS
//   none; column heights and result width are fixed for 13x13 operation.
// PORTS
//   clk    in   1   clock; all state updates on rising edge.
//   rst    in   1   synchronous, active-high reset.
//   srcK   in   hK  column K bits, K=0..24, hK=min(K+1,25-K); each bit has weight 2^K.
//   dstK   out  1   result bit K, K=0..25; bit weight 2^K.
// BEHAVIOUR
//   - Function: S = sum over K of popcount(srcK) * 2^K; dstK = S[K].
//     Max S = (2^13-1)^2 = 0x3FFC001 < 2^26, so there is never an overflow and no carry-out.
//   - Order of bits within a column is irrelevant (all bits in srcK are equal weight).
//   - Stage 1 (comb + reg): full/half-adder (3:2, 2:2) tree reduces every
//     column to height <=2; both rows are registered (27 bits each, upper bits 0).
//   - Stage 2 (comb + reg): carry-propagate add of the two rows; the low 26 bits
//     are registered into dst0..dst25.
//   - Latency exactly 2 clk cycles from src sample to dst; throughput 1 vector/cycle;
//     no handshake, no stall.
//   - Reset: while rst=1 at a rising edge, both stage registers clear to 0;
//     dst0..dst25 = 0 from the cycle after reset is sampled. A reset mid-stream
//     discards in-flight vectors; the first post-reset vector appears 2 cycles
//     after it is sampled. Initial power-up value of all registers is also 0.
//   - Inputs are sampled on every rising edge with rst=0; no internal state other
//     than the two pipeline stages.
//   - Purely unsigned arithmetic; no X propagation required beyond reset.
// TESTING
//   - All src=0 -> two cycles later all dst=0.
//   - All src bits=1 -> S=0x3FFC001: dst0=1, dst14..dst25=1, all others 0.
//   - Only src24[0]=1 -> dst24=1, all other dst=0 (no spurious carries).
//   - src12 = all 13 ones, others 0 -> S=13*2^12=0xD000: dst12,dst14,dst15=1, rest 0.
//   - Back-to-back vectors A,B,C on consecutive cycles -> S(A),S(B),S(C) appear
//     on consecutive cycles starting 2 cycles after A; compare against a
//     popcount-weighted golden model with 10k random vectors.
//   - Assert rst for 1 cycle while two vectors are in flight -> dst=0 on the next
//     cycle, neither flushed vector ever appears; next vector arrives 2 cycles later.

Source files
------------

// File: rtl/pp_compressor_mul13.sv
`default_nettype none
// ============================================================================
// Module      : pp_compressor_mul13
// Description : Two-stage partial-product compressor for a 13x13 unsigned
//               multiplier. Column K (K=0..24) carries min(K+1,25-K) bits
//               of weight 2^K. Stage 1 reduces every column to at most two
//               bits with 3:2 counters and registers the two rows. Stage 2
//               adds the rows and registers the 26-bit product.
// Ports       : clk          rising-edge clock
//               rst          synchronous active-high reset
//               src0..src24  column bits, src K is min(K+1,25-K) wide
//               dst0..dst25  product bit K, weight 2^K
// Latency     : 2 clocks, one vector per clock, no stall
// Revision    : 1.0 - initial release
// ============================================================================
module pp_compressor_mul13 (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:0]  src0,
    input  logic [1:0]  src1,
    input  logic [2:0]  src2,
    input  logic [3:0]  src3,
    input  logic [4:0]  src4,
    input  logic [5:0]  src5,
    input  logic [6:0]  src6,
    input  logic [7:0]  src7,
    input  logic [8:0]  src8,
    input  logic [9:0]  src9,
    input  logic [10:0] src10,
    input  logic [11:0] src11,
    input  logic [12:0] src12,
    input  logic [11:0] src13,
    input  logic [10:0] src14,
    input  logic [9:0]  src15,
    input  logic [8:0]  src16,
    input  logic [7:0]  src17,
    input  logic [6:0]  src18,
    input  logic [5:0]  src19,
    input  logic [4:0]  src20,
    input  logic [3:0]  src21,
    input  logic [2:0]  src22,
    input  logic [1:0]  src23,
    input  logic [0:0]  src24,
    output logic        dst0,  output logic dst1,  output logic dst2,
    output logic        dst3,  output logic dst4,  output logic dst5,
    output logic        dst6,  output logic dst7,  output logic dst8,
    output logic        dst9,  output logic dst10, output logic dst11,
    output logic        dst12, output logic dst13, output logic dst14,
    output logic        dst15, output logic dst16, output logic dst17,
    output logic        dst18, output logic dst19, output logic dst20,
    output logic        dst21, output logic dst22, output logic dst23,
    output logic        dst24, output logic dst25
);

    // 27 row columns plus one spare column so the carry write from the last
    // reduced column always has a legal target.
    localparam int c_COLS  = 28;
    localparam int c_MAXH  = 32;   // tallest column seen during reduction is 23
    localparam int c_ITERS = 16;   // enough 3:2 steps to bring 23 bits down to 2

    logic [c_MAXH-1:0] w_col [c_COLS];
    int                w_hgt [c_COLS];
    logic [4:0]        w_base;
    logic              w_fa_a;
    logic              w_fa_b;
    logic              w_fa_c;
    logic [26:0]       w_row_a;
    logic [26:0]       w_row_b;
    logic [25:0]       w_sum;

    logic [26:0]       r_row_a;
    logic [26:0]       r_row_b;
    logic [25:0]       r_sum;

    // ------------------------------------------------------------------
    // Stage 1: column compression. Columns are processed LSB first so the
    // carries a column produces are already present when the next column
    // is reduced. Each 3:2 counter takes the top three bits of a column,
    // leaves the sum in place and pushes the carry onto the next column.
    // ------------------------------------------------------------------
    always_comb begin
        w_base = '0;
        w_fa_a = 1'b0;
        w_fa_b = 1'b0;
        w_fa_c = 1'b0;
        for (int k = 0; k < c_COLS; k++) begin
            w_col[k] = '0;
            w_hgt[k] = 0;
        end

        w_col[0][0:0]   = src0;   w_col[1][1:0]   = src1;
        w_col[2][2:0]   = src2;   w_col[3][3:0]   = src3;
        w_col[4][4:0]   = src4;   w_col[5][5:0]   = src5;
        w_col[6][6:0]   = src6;   w_col[7][7:0]   = src7;
        w_col[8][8:0]   = src8;   w_col[9][9:0]   = src9;
        w_col[10][10:0] = src10;  w_col[11][11:0] = src11;
        w_col[12][12:0] = src12;  w_col[13][11:0] = src13;
        w_col[14][10:0] = src14;  w_col[15][9:0]  = src15;
        w_col[16][8:0]  = src16;  w_col[17][7:0]  = src17;
        w_col[18][6:0]  = src18;  w_col[19][5:0]  = src19;
        w_col[20][4:0]  = src20;  w_col[21][3:0]  = src21;
        w_col[22][2:0]  = src22;  w_col[23][1:0]  = src23;
        w_col[24][0:0]  = src24;

        for (int k = 0; k < 25; k++) begin
            w_hgt[k] = (k < 13) ? (k + 1) : (25 - k);
        end

        for (int k = 0; k < c_COLS - 1; k++) begin
            for (int it = 0; it < c_ITERS; it++) begin
                if (w_hgt[k] > 2) begin
                    w_base = 5'(w_hgt[k] - 3);
                    w_fa_a = w_col[k][w_base];
                    w_fa_b = w_col[k][w_base + 5'd1];
                    w_fa_c = w_col[k][w_base + 5'd2];
                    w_col[k][w_base]        = w_fa_a ^ w_fa_b ^ w_fa_c;
                    w_col[k][w_base + 5'd1] = 1'b0;
                    w_col[k][w_base + 5'd2] = 1'b0;
                    w_col[k+1][5'(w_hgt[k+1])] = (w_fa_a & w_fa_b) |
                                                 (w_fa_a & w_fa_c) |
                                                 (w_fa_b & w_fa_c);
                    w_hgt[k+1] = w_hgt[k+1] + 1;
                    w_hgt[k]   = w_hgt[k] - 2;
                end
            end
        end

        for (int k = 0; k < 27; k++) begin
            w_row_a[k] = w_col[k][0];
            w_row_b[k] = w_col[k][1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: carry-propagate add. The true product is below 2^26, so the
    // truncated sum is exact.
    // ------------------------------------------------------------------
    assign w_sum = 26'(r_row_a + r_row_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_a <= '0;
            r_row_b <= '0;
            r_sum   <= '0;
        end else begin
            r_row_a <= w_row_a;
            r_row_b <= w_row_b;
            r_sum   <= w_sum;
        end
    end

    assign {dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17,
            dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,
            dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_pp_compressor_mul13.sv
`default_nettype none
// ============================================================================
// Module      : tb_pp_compressor_mul13
// Description : Scoreboard bench for pp_compressor_mul13. Each driven vector
//               pushes its popcount-weighted sum with the cycle it is due;
//               entries are popped and compared when that cycle arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_compressor_mul13;

    typedef struct {
        int          due;
        logic [31:0] val;
        logic [63:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] tsrc [25];
    logic [12:0] nsrc [25];
    logic        dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,  dst8;
    logic        dst9,  dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17;
    logic        dst18, dst19, dst20, dst21, dst22, dst23, dst24, dst25;
    logic [25:0] obs;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pp_compressor_mul13 dut (
        .clk(clk), .rst(rst),
        .src0(tsrc[0][0:0]),    .src1(tsrc[1][1:0]),    .src2(tsrc[2][2:0]),
        .src3(tsrc[3][3:0]),    .src4(tsrc[4][4:0]),    .src5(tsrc[5][5:0]),
        .src6(tsrc[6][6:0]),    .src7(tsrc[7][7:0]),    .src8(tsrc[8][8:0]),
        .src9(tsrc[9][9:0]),    .src10(tsrc[10][10:0]), .src11(tsrc[11][11:0]),
        .src12(tsrc[12][12:0]), .src13(tsrc[13][11:0]), .src14(tsrc[14][10:0]),
        .src15(tsrc[15][9:0]),  .src16(tsrc[16][8:0]),  .src17(tsrc[17][7:0]),
        .src18(tsrc[18][6:0]),  .src19(tsrc[19][5:0]),  .src20(tsrc[20][4:0]),
        .src21(tsrc[21][3:0]),  .src22(tsrc[22][2:0]),  .src23(tsrc[23][1:0]),
        .src24(tsrc[24][0:0]),
        .dst0(dst0),   .dst1(dst1),   .dst2(dst2),   .dst3(dst3),   .dst4(dst4),
        .dst5(dst5),   .dst6(dst6),   .dst7(dst7),   .dst8(dst8),   .dst9(dst9),
        .dst10(dst10), .dst11(dst11), .dst12(dst12), .dst13(dst13), .dst14(dst14),
        .dst15(dst15), .dst16(dst16), .dst17(dst17), .dst18(dst18), .dst19(dst19),
        .dst20(dst20), .dst21(dst21), .dst22(dst22), .dst23(dst23), .dst24(dst24),
        .dst25(dst25)
    );

    assign obs = {dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17,
                  dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,
                  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

    task automatic check_eq(input logic [63:0] tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Golden product: each column contributes popcount(bits) * 2^K.
    function automatic logic [31:0] golden();
        logic [31:0] s;
        logic [12:0] m;
        int          h;
        s = '0;
        for (int k = 0; k < 25; k++) begin
            h = (k < 13) ? (k + 1) : (25 - k);
            m = 13'((32'd1 << h) - 32'd1);
            s = s + (32'($countones(tsrc[k] & m)) << k);
        end
        return s;
    endfunction

    task automatic pop_due();
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check_eq(e.tag, {6'd0, obs}, e.val);
        end
    endtask

    // One clock: compare whatever is due, then present nsrc. A reset cycle
    // discards everything in flight and expects zeros on the next two cycles.
    task automatic tick(input logic do_rst, input logic [63:0] tag);
        @(negedge clk);
        pop_due();
        for (int k = 0; k < 25; k++) tsrc[k] = nsrc[k];
        rst = do_rst;
        if (do_rst) begin
            q.delete();
            q.push_back('{due: cyc + 1, val: 32'd0, tag: "rst"});
            q.push_back('{due: cyc + 2, val: 32'd0, tag: "rstflush"});
        end else begin
            q.push_back('{due: cyc + 2, val: golden(), tag: tag});
        end
    endtask

    task automatic fill(input logic [12:0] v);
        for (int k = 0; k < 25; k++) nsrc[k] = v;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 7))
                0:       nsrc[k] = 13'd0;
                1:       nsrc[k] = 13'h1FFF;
                default: nsrc[k] = 13'($urandom);
            endcase
        end
    endtask

    initial begin
        for (int k = 0; k < 25; k++) tsrc[k] = '0;
        fill(13'd0);
        tick(1'b1, "rst");
        tick(1'b1, "rst");

        fill(13'd0);            tick(1'b0, "zero");
        fill(13'h1FFF);         tick(1'b0, "ones");
        fill(13'd0);  nsrc[24] = 13'd1;      tick(1'b0, "top");
        fill(13'd0);  nsrc[12] = 13'h1FFF;   tick(1'b0, "col12");
        fill(13'd0);            tick(1'b0, "zero2");

        for (int k = 0; k < 25; k++) begin
            fill(13'd0);
            nsrc[k] = 13'd1;
            tick(1'b0, "single");
        end

        // Reset with vectors in flight; the vector offered during reset
        // must also be dropped.
        fill(13'h1FFF);         tick(1'b0, "pre_a");
        fill_rand();            tick(1'b0, "pre_b");
        fill(13'h1FFF);         tick(1'b0, "pre_c");
        fill(13'h0AAA);         tick(1'b1, "rst");
        fill(13'h1FFF);         tick(1'b0, "post");
        fill_rand();            tick(1'b0, "post2");

        for (int i = 0; i < 10000; i++) begin
            fill_rand();
            tick(1'b0, "rand");
        end

        fill(13'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pop_due();
        end
        check_eq("qempty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
`default_nettype wire
